// File: rtl/fifo_img_pkg.sv
// Shared constants and bus-slicing helpers for the 16-lane 3x3 window generator.
package fifo_img_pkg;
    localparam int LANES     = 16;
    localparam int WIN_ELEMS = 9;
    localparam int MAX_ROW   = 127;
    localparam int COL_W     = 7;
    localparam int ROW_W     = 12;
    localparam int CNT_W     = 12;

    // Low bit of lane `lane` inside the packed input pixel bus.
    function automatic int pix_lo(input int lane, input int w);
        return lane * w;
    endfunction

    // Low bit of element `k` of lane `lane` inside the packed window bus.
    function automatic int win_lo(input int lane, input int k, input int w);
        return (lane * WIN_ELEMS + k) * w;
    endfunction
endpackage

// File: rtl/fifo3x3.sv
// One channel lane: two column-addressed line buffers and a 3x3 shifting window.
module fifo3x3
    import fifo_img_pkg::*;
#(
    parameter int bitsize = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr,
    input  logic [COL_W-1:0]               col,
    input  logic signed [bitsize-1:0]      pixel,
    output logic [WIN_ELEMS*bitsize-1:0]   window
);
    logic signed [bitsize-1:0] lb_mid [MAX_ROW];
    logic signed [bitsize-1:0] lb_top [MAX_ROW];
    logic signed [bitsize-1:0] win_p0 [WIN_ELEMS];

    // Line buffers are indexed by column, so a variable row_size needs no shift chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_ROW; i++) begin
                lb_mid[i] <= '0;
                lb_top[i] <= '0;
            end
            for (int k = 0; k < WIN_ELEMS; k++) begin
                win_p0[k] <= '0;
            end
        end else if (wr) begin
            lb_top[col] <= lb_mid[col];
            lb_mid[col] <= pixel;
            win_p0[0]   <= win_p0[1];
            win_p0[1]   <= win_p0[2];
            win_p0[2]   <= lb_top[col];
            win_p0[3]   <= win_p0[4];
            win_p0[4]   <= win_p0[5];
            win_p0[5]   <= lb_mid[col];
            win_p0[6]   <= win_p0[7];
            win_p0[7]   <= win_p0[8];
            win_p0[8]   <= pixel;
        end
    end

    for (genvar k = 0; k < WIN_ELEMS; k++) begin : g_out
        assign window[k*bitsize +: bitsize] = win_p0[k];
    end
endmodule

// File: rtl/fifo_image_input_x16.sv
// 16-lane 3x3 sliding-window generator with shared raster control.
// Macro FIFO_IMG_OUTREG_EN adds one output register stage (latency 2).
module fifo_image_input_x16
    import fifo_img_pkg::*;
#(
    parameter int bitsize   = 14,
    parameter int FRAC_BITS = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [LANES*bitsize-1:0]              input_pixels,
    input  logic                                  wr_en,
    input  logic                                  stride,
    input  logic [6:0]                            row_size,
    input  logic [11:0]                           full_window_size,
    input  logic                                  EX_Window_Done,
    input  logic                                  Zero_Buffreing,
    output logic                                  data_valid,
    output logic                                  depth_window_done,
    output logic [WIN_ELEMS*LANES*bitsize-1:0]    output_window
);
    if (FRAC_BITS >= bitsize) begin : g_frac_check
        $error("FRAC_BITS must be smaller than bitsize");
    end

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             skip_row;
    logic [CNT_W-1:0] win_cnt;
    logic             wr;
    logic             col_wrap;
    logic             win_ok;
    logic             last_win;
    logic             vld_p0;
    logic             done_p0;
    logic [WIN_ELEMS*LANES*bitsize-1:0] win_bus;

    assign wr       = wr_en && !EX_Window_Done;
    assign col_wrap = (col == row_size - 7'd1);
    // Odd column / odd row positions are dropped for stride 2.
    assign win_ok   = (col >= COL_W'(2)) && (row >= ROW_W'(2)) &&
                      (!stride || (!skip_row && !col[0]));
    assign last_win = win_ok && (full_window_size != '0) &&
                      (win_cnt + 12'd1 == full_window_size);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col      <= '0;
            row      <= '0;
            skip_row <= 1'b0;
            win_cnt  <= '0;
            vld_p0   <= 1'b0;
            done_p0  <= 1'b0;
        end else begin
            vld_p0  <= wr && win_ok;
            done_p0 <= wr && last_win;
            if (EX_Window_Done || (wr && last_win)) begin
                col      <= '0;
                row      <= '0;
                skip_row <= 1'b0;
                win_cnt  <= '0;
            end else if (wr) begin
                if (win_ok) begin
                    win_cnt <= win_cnt + 12'd1;
                end
                if (col_wrap) begin
                    col      <= '0;
                    row      <= row + ROW_W'(1);
                    // Next row is skipped when it is row 1 or (row-2) is odd.
                    skip_row <= !row[0];
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [bitsize-1:0] pixel;
        assign pixel = Zero_Buffreing ? '0 : input_pixels[pix_lo(g, bitsize) +: bitsize];
        fifo3x3 #(.bitsize(bitsize)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .wr     (wr),
            .col    (col),
            .pixel  (pixel),
            .window (win_bus[win_lo(g, 0, bitsize) +: WIN_ELEMS*bitsize])
        );
    end

`ifdef FIFO_IMG_OUTREG_EN
    logic                               vld_p1;
    logic                               done_p1;
    logic [WIN_ELEMS*LANES*bitsize-1:0] win_p1;

    // Output register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            win_p1  <= '0;
        end else begin
            vld_p1  <= vld_p0;
            done_p1 <= done_p0;
            win_p1  <= win_bus;
        end
    end

    assign data_valid        = vld_p1;
    assign depth_window_done = done_p1;
    assign output_window     = win_p1;
`else
    assign data_valid        = vld_p0;
    assign depth_window_done = done_p0;
    assign output_window     = win_bus;
`endif
endmodule

// File: tb/tb_fifo_image_input_x16.sv
// Bench for fifo_image_input_x16: image-coordinate reference model plus directed scenarios.
module tb_fifo_image_input_x16;
    localparam int W  = 14;
    localparam int NL = 16;
    localparam int WB = 9*NL*W;
`ifdef FIFO_IMG_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NL*W-1:0] input_pixels = '0;
    logic            wr_en = 1'b0;
    logic            stride = 1'b0;
    logic [6:0]      row_size = 7'd4;
    logic [11:0]     full_window_size = '0;
    logic            EX_Window_Done = 1'b0;
    logic            Zero_Buffreing = 1'b0;
    logic            data_valid;
    logic            depth_window_done;
    logic [WB-1:0]   output_window;

    int total = 0;
    int bad   = 0;

    fifo_image_input_x16 dut (
        .clk               (clk),
        .rst               (rst),
        .input_pixels      (input_pixels),
        .wr_en             (wr_en),
        .stride            (stride),
        .row_size          (row_size),
        .full_window_size  (full_window_size),
        .EX_Window_Done    (EX_Window_Done),
        .Zero_Buffreing    (Zero_Buffreing),
        .data_valid        (data_valid),
        .depth_window_done (depth_window_done),
        .output_window     (output_window)
    );

    always #5 clk = ~clk;

    // Reference model: pixels are stored by image coordinate (row mod 3, col).
    logic signed [W-1:0] img [NL][3][128];
    int          m_n, m_cnt, m_r, m_c;
    bit          m_ok, m_dn;
    logic [WB-1:0] ew;
    logic          e_v [2];
    logic          e_d [2];
    logic [WB-1:0] e_w [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n = 0; m_cnt = 0;
            e_v[0] = 0; e_v[1] = 0; e_d[0] = 0; e_d[1] = 0;
            e_w[0] = '0; e_w[1] = '0;
        end else begin
            m_ok = 0; m_dn = 0;
            if (EX_Window_Done) begin
                m_n = 0; m_cnt = 0;
            end else if (wr_en) begin
                m_r = m_n / int'(row_size);
                m_c = m_n % int'(row_size);
                for (int l = 0; l < NL; l++)
                    img[l][m_r % 3][m_c] = Zero_Buffreing ? '0 : input_pixels[l*W +: W];
                m_ok = (m_c >= 2) && (m_r >= 2) &&
                       (!stride || (((m_c - 2) % 2 == 0) && ((m_r - 2) % 2 == 0)));
                m_n++;
                if (m_ok) begin
                    for (int l = 0; l < NL; l++)
                        for (int k = 0; k < 9; k++)
                            ew[(l*9+k)*W +: W] = img[l][(m_r - 2 + k/3) % 3][m_c - 2 + k%3];
                    m_cnt++;
                    if (full_window_size != 0 && m_cnt == int'(full_window_size)) begin
                        m_dn = 1; m_n = 0; m_cnt = 0;
                    end
                end
            end
            e_v[1] = e_v[0]; e_d[1] = e_d[0]; e_w[1] = e_w[0];
            e_v[0] = m_ok;   e_d[0] = m_dn;
            if (m_ok) e_w[0] = ew;
        end
    end

    logic [WB-1:0] win_log [$];
    int            done_log [$];

    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (data_valid !== e_v[LAT-1]) begin
                bad++;
                $display("FAIL data_valid t=%0t: got %b want %b", $time, data_valid, e_v[LAT-1]);
            end
            total++;
            if (depth_window_done !== e_d[LAT-1]) begin
                bad++;
                $display("FAIL depth_done t=%0t: got %b want %b", $time, depth_window_done, e_d[LAT-1]);
            end
            if (e_v[LAT-1]) begin
                total++;
                if (output_window !== e_w[LAT-1]) begin
                    bad++;
                    for (int l = 0; l < NL; l++) begin
                        if (output_window[l*9*W +: 9*W] !== e_w[LAT-1][l*9*W +: 9*W]) begin
                            $display("FAIL window t=%0t lane %0d: got %h want %h", $time, l,
                                     output_window[l*9*W +: 9*W], e_w[LAT-1][l*9*W +: 9*W]);
                            break;
                        end
                    end
                end
            end
            if (data_valid === 1'b1) win_log.push_back(output_window);
            if (depth_window_done === 1'b1) done_log.push_back(win_log.size());
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; pixel of lane l is base+32*l, negated on odd lanes, or random.
    task automatic drive(input bit w, input bit z, input bit ex, input int base, input bit rnd);
        int pv;
        @(negedge clk);
        wr_en = w; Zero_Buffreing = z; EX_Window_Done = ex;
        for (int l = 0; l < NL; l++) begin
            pv = base + 32*l;
            if (l % 2 == 1) pv = -pv;
            input_pixels[l*W +: W] = rnd ? W'($urandom) : W'(pv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    int            b, d;
    int            lit [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    logic [WB-1:0] wv;
    logic [9*W-1:0] exp0, exp1;
    bit            ok, seen;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_valid", 128'(data_valid), 128'd0);
        chk("reset_done", 128'(depth_window_done), 128'd0);
        chk("reset_window_nz", 128'(|output_window), 128'd0);
        rst = 1'b1;
        idle(2);

        // stride 1 on a 4-wide image: four windows, slice closes on the fourth
        stride = 0; row_size = 7'd4; full_window_size = 12'd4;
        b = win_log.size(); d = done_log.size();
        for (int i = 1; i <= 16; i++) drive(1, 0, 0, i, 0);
        idle(3);
        chk("s1_count", 128'(win_log.size() - b), 128'd4);
        chk("s1_done_count", 128'(done_log.size() - d), 128'd1);
        if (done_log.size() > d) chk("s1_done_idx", 128'(done_log[d] - b), 128'd4);
        if (win_log.size() > b) begin
            wv = win_log[b];
            for (int k = 0; k < 9; k++) begin
                exp0[k*W +: W] = W'(lit[k]);
                exp1[k*W +: W] = W'(-(lit[k] + 32));
            end
            chk("s1_first_lane0", 128'(wv[0 +: 9*W]), 128'(exp0));
            chk("s1_first_lane1", 128'(wv[9*W +: 9*W]), 128'(exp1));
        end

        // stride 2 on a 112x112 image: 55*55 windows, done on the last
        stride = 1; row_size = 7'd112; full_window_size = 12'd3025;
        b = win_log.size(); d = done_log.size();
        for (int i = 0; i < 112*112; i++) drive(1, 0, 0, 0, 1);
        idle(3);
        chk("s2_count", 128'(win_log.size() - b), 128'd3025);
        chk("s2_done_count", 128'(done_log.size() - d), 128'd1);
        if (done_log.size() > d) chk("s2_done_idx", 128'(done_log[d] - b), 128'd3025);

        // Zero-padded first row: top row of the first windows is 0 in every lane
        drive(0, 0, 1, 0, 0);
        stride = 0; row_size = 7'd5; full_window_size = 12'd0;
        idle(2);
        b = win_log.size(); d = done_log.size();
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 100 + i, 0);
        for (int i = 0; i < 15; i++) drive(1, 0, 0, 200 + i, 0);
        idle(3);
        chk("pad_count", 128'(win_log.size() - b), 128'd6);
        if (win_log.size() > b) begin
            wv = win_log[b];
            ok = 1;
            for (int l = 0; l < NL; l++)
                for (int k = 0; k < 3; k++)
                    if (wv[(l*9+k)*W +: W] !== '0) ok = 0;
            chk("pad_top_row_zero", 128'(ok), 128'd1);
            chk("pad_mid_lane0", 128'(wv[3*W +: W]), 128'(W'(200)));
        end
        chk("pad_no_done", 128'(done_log.size() - d), 128'd0);

        // Restart with a simultaneous write: dropped pixel, 2 rows + 3 pixels to first window
        drive(1, 0, 1, 300, 0);
        idle(3);
        b = win_log.size();
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 400 + i, 0);
        idle(3);
        chk("ex_before", 128'(win_log.size() - b), 128'd0);
        drive(1, 0, 0, 412, 0);
        idle(3);
        chk("ex_after", 128'(win_log.size() - b), 128'd1);

        // Random write gaps
        drive(0, 0, 1, 0, 0);
        row_size = 7'd6;
        idle(2);
        b = win_log.size(); d = done_log.size();
        for (int i = 0; i < 24; i++) begin
            drive(1, 0, 0, 500 + i, 0);
            repeat ($urandom_range(0, 3)) drive(0, 0, 0, 0, 0);
        end
        idle(3);
        chk("gap_count", 128'(win_log.size() - b), 128'd8);
        chk("gap_no_done", 128'(done_log.size() - d), 128'd0);

        // Asynchronous reset while a window is being presented
        drive(0, 0, 1, 0, 0);
        row_size = 7'd4;
        idle(2);
        for (int i = 1; i <= 11; i++) drive(1, 0, 0, i, 0);
        seen = 0;
        for (int t = 0; t < 6; t++) begin
            drive(0, 0, 0, 0, 0);
            if (data_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("rst_pre_valid", 128'(seen), 128'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_valid", 128'(data_valid), 128'd0);
        chk("rst_async_done", 128'(depth_window_done), 128'd0);
        chk("rst_async_window_nz", 128'(|output_window), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
